// File: rtl/serdesphy_seq_pkg.sv
// Shared definitions for the SerDes PHY link bring-up sequencer.
// Holds the state encodings, the wait/retry counter widths and a small
// decode helper used by the output logic.
package serdesphy_seq_pkg;

    localparam int unsigned WAIT_W  = 16;
    localparam int unsigned RETRY_W = 4;

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_PLL_RST  = 3'd1;
    localparam logic [2:0] ST_PLL_WAIT = 3'd2;
    localparam logic [2:0] ST_CDR_RST  = 3'd3;
    localparam logic [2:0] ST_CDR_WAIT = 3'd4;
    localparam logic [2:0] ST_ALIGN    = 3'd5;
    localparam logic [2:0] ST_UP       = 3'd6;
    localparam logic [2:0] ST_ERR      = 3'd7;

    // RX datapath is live from CDR reset through link up.
    function automatic logic st_rx_active(input logic [2:0] st);
        return (st >= ST_CDR_RST) && (st <= ST_UP);
    endfunction

endpackage

// File: rtl/serdesphy_lock_filter.sv
// Lock qualification filter.
// Counts consecutive cycles with lock_in high, saturating at STABLE.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - clears the count (driven by the matching reset output)
//   lock_in   - raw lock from the analog block
//   stable    - count, including the current sample, has reached STABLE
module serdesphy_lock_filter
    import serdesphy_seq_pkg::*;
#(
    parameter int unsigned STABLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic lock_in,
    output logic stable
);

    localparam int unsigned CntW = $clog2(STABLE + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !lock_in) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Stable is judged on the count that includes this cycle's sample, so the
    // sequencer leaves a wait state on the edge that registers the last good
    // sample rather than one edge later.
    assign stable = (cnt_d == CntMax);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serdesphy_link_seq.sv
// SerDes PHY link bring-up sequencer.
// Sequences PLL reset/lock, CDR reset/lock, RX alignment reset and TX idle
// release with lock filtering, timeouts and bounded retries.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   phy_en, *_cfg            - CSR enables and forced overrides
//   err_clr                  - pulse clearing sticky flags and retry count
//   pll_lock, cdr_lock       - raw analog lock indications
//   pll_rst_o .. tx_idle_o   - PHY control outputs
//   link_up, seq_state       - status
//   *_err, retry_cnt         - sticky error flags and failed attempt count
module serdesphy_link_seq
    import serdesphy_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = 24,
    parameter int unsigned CDR_RST_CYCLES     = 8,
    parameter int unsigned LOCK_STABLE_CYCLES = 16,
    parameter int unsigned PLL_LOCK_TIMEOUT   = 2400,
    parameter int unsigned CDR_LOCK_TIMEOUT   = 1200,
    parameter int unsigned MAX_RETRY          = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               phy_en,
    input  logic               tx_en_cfg,
    input  logic               rx_en_cfg,
    input  logic               pll_rst_cfg,
    input  logic               cdr_rst_cfg,
    input  logic               tx_idle_cfg,
    input  logic               err_clr,
    input  logic               pll_lock,
    input  logic               cdr_lock,
    output logic               pll_rst_o,
    output logic               cdr_rst_o,
    output logic               tx_en_o,
    output logic               rx_en_o,
    output logic               rx_align_rst_o,
    output logic               tx_idle_o,
    output logic               link_up,
    output logic [2:0]         seq_state,
    output logic               pll_timeout_err,
    output logic               cdr_timeout_err,
    output logic               lock_loss_err,
    output logic [RETRY_W-1:0] retry_cnt
);

    // Counter loads are N-1 so a state lasts exactly N cycles.
    localparam logic [WAIT_W-1:0]  PllRstLoad = WAIT_W'(PLL_RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  CdrRstLoad = WAIT_W'(CDR_RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  PllToLoad  = WAIT_W'(PLL_LOCK_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]  CdrToLoad  = WAIT_W'(CDR_LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RetryMax   = RETRY_W'(MAX_RETRY);

    logic [2:0]         state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_to_q, pll_to_d;
    logic               cdr_to_q, cdr_to_d;
    logic               loss_q, loss_d;

    logic               pll_to_set, cdr_to_set, loss_set, retry_inc;
    logic [RETRY_W-1:0] retry_nxt;
    logic               pll_stable, cdr_stable;

    serdesphy_lock_filter #(
        .STABLE (LOCK_STABLE_CYCLES)
    ) u_pll_filter (
        .clk     (clk),
        .rst     (rst),
        .clr     (pll_rst_o),
        .lock_in (pll_lock),
        .stable  (pll_stable)
    );

    serdesphy_lock_filter #(
        .STABLE (LOCK_STABLE_CYCLES)
    ) u_cdr_filter (
        .clk     (clk),
        .rst     (rst),
        .clr     (cdr_rst_o),
        .lock_in (cdr_lock),
        .stable  (cdr_stable)
    );

    assign retry_nxt = retry_q + RETRY_W'(1);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        pll_to_set = 1'b0;
        cdr_to_set = 1'b0;
        loss_set   = 1'b0;
        retry_inc  = 1'b0;

        if (!phy_en) begin
            state_d = ST_OFF;
            wait_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_PLL_RST;
                    wait_d  = PllRstLoad;
                end
                ST_PLL_RST: begin
                    if (wait_q == '0) begin
                        state_d = ST_PLL_WAIT;
                        wait_d  = PllToLoad;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                ST_PLL_WAIT: begin
                    if (pll_rst_cfg) begin
                        // Forced reset: the timeout window restarts on release.
                        wait_d = PllToLoad;
                    end else if (pll_stable) begin
                        state_d = ST_CDR_RST;
                        wait_d  = CdrRstLoad;
                    end else if (wait_q == '0) begin
                        pll_to_set = 1'b1;
                        retry_inc  = 1'b1;
                        state_d    = (retry_nxt >= RetryMax) ? ST_ERR : ST_PLL_RST;
                        wait_d     = PllRstLoad;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                ST_CDR_RST: begin
                    if (wait_q == '0) begin
                        state_d = ST_CDR_WAIT;
                        wait_d  = CdrToLoad;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                ST_CDR_WAIT: begin
                    if (cdr_rst_cfg) begin
                        wait_d = CdrToLoad;
                    end else if (cdr_stable) begin
                        state_d = ST_ALIGN;
                    end else if (wait_q == '0) begin
                        cdr_to_set = 1'b1;
                        retry_inc  = 1'b1;
                        state_d    = (retry_nxt >= RetryMax) ? ST_ERR : ST_CDR_RST;
                        wait_d     = CdrRstLoad;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                ST_ALIGN: begin
                    state_d = ST_UP;
                end
                ST_UP: begin
                    // Raw locks here: any drop takes the link down immediately.
                    if (!pll_lock || pll_rst_cfg) begin
                        loss_set = 1'b1;
                        state_d  = ST_PLL_RST;
                        wait_d   = PllRstLoad;
                    end else if (!cdr_lock || cdr_rst_cfg) begin
                        loss_set = 1'b1;
                        state_d  = ST_CDR_RST;
                        wait_d   = CdrRstLoad;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_OFF;
                    wait_d  = '0;
                end
            endcase
        end

        // Sticky flags: a set beats a simultaneous clear.
        pll_to_d = pll_to_set | (pll_to_q & ~err_clr);
        cdr_to_d = cdr_to_set | (cdr_to_q & ~err_clr);
        loss_d   = loss_set   | (loss_q   & ~err_clr);

        if (retry_inc) begin
            retry_d = retry_nxt;
        end else if (err_clr || !phy_en) begin
            retry_d = '0;
        end else begin
            retry_d = retry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            wait_q   <= '0;
            retry_q  <= '0;
            pll_to_q <= 1'b0;
            cdr_to_q <= 1'b0;
            loss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            retry_q  <= retry_d;
            pll_to_q <= pll_to_d;
            cdr_to_q <= cdr_to_d;
            loss_q   <= loss_d;
        end
    end

    always_comb begin
        pll_rst_o      = (state_q == ST_OFF) || (state_q == ST_PLL_RST) ||
                         (state_q == ST_ERR) || pll_rst_cfg;
        cdr_rst_o      = !((state_q == ST_CDR_WAIT) || (state_q == ST_ALIGN) ||
                           (state_q == ST_UP)) || cdr_rst_cfg;
        rx_en_o        = rx_en_cfg && st_rx_active(state_q);
        tx_en_o        = tx_en_cfg && ((state_q == ST_ALIGN) || (state_q == ST_UP));
        rx_align_rst_o = !((state_q == ST_ALIGN) || (state_q == ST_UP));
        tx_idle_o      = !((state_q == ST_UP) && !tx_idle_cfg);
        link_up        = (state_q == ST_UP);
    end

    assign seq_state       = state_q;
    assign pll_timeout_err = pll_to_q;
    assign cdr_timeout_err = cdr_to_q;
    assign lock_loss_err   = loss_q;
    assign retry_cnt       = retry_q;

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// Self-checking bench for serdesphy_link_seq: a table of per-cycle vectors for
// nominal bring-up and output decode, plus directed multi-cycle sequences.
module tb_serdesphy_link_seq;

    localparam logic [2:0] S_OFF = 3'd0, S_PRST = 3'd1, S_PWAIT = 3'd2, S_CRST = 3'd3;
    localparam logic [2:0] S_CWAIT = 3'd4, S_ALIGN = 3'd5, S_UP = 3'd6, S_ERR = 3'd7;

    // Output vector: {pll_rst, cdr_rst, rx_en, tx_en, align_rst, tx_idle, link_up}
    localparam logic [6:0] O_OFF   = 7'b1100110;
    localparam logic [6:0] O_PWAIT = 7'b0100110;
    localparam logic [6:0] O_CRST  = 7'b0110110;
    localparam logic [6:0] O_CWAIT = 7'b0010110;
    localparam logic [6:0] O_ALIGN = 7'b0011010;
    localparam logic [6:0] O_UP    = 7'b0011001;

    logic clk = 1'b0;
    logic rst, phy_en, tx_en_cfg, rx_en_cfg, pll_rst_cfg, cdr_rst_cfg, tx_idle_cfg;
    logic err_clr, pll_lock, cdr_lock;
    logic pll_rst_o, cdr_rst_o, tx_en_o, rx_en_o, rx_align_rst_o, tx_idle_o, link_up;
    logic [2:0] seq_state;
    logic pll_timeout_err, cdr_timeout_err, lock_loss_err;
    logic [3:0] retry_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serdesphy_link_seq #(
        .PLL_RST_CYCLES     (4),
        .CDR_RST_CYCLES     (2),
        .LOCK_STABLE_CYCLES (3),
        .PLL_LOCK_TIMEOUT   (20),
        .CDR_LOCK_TIMEOUT   (20),
        .MAX_RETRY          (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .phy_en          (phy_en),
        .tx_en_cfg       (tx_en_cfg),
        .rx_en_cfg       (rx_en_cfg),
        .pll_rst_cfg     (pll_rst_cfg),
        .cdr_rst_cfg     (cdr_rst_cfg),
        .tx_idle_cfg     (tx_idle_cfg),
        .err_clr         (err_clr),
        .pll_lock        (pll_lock),
        .cdr_lock        (cdr_lock),
        .pll_rst_o       (pll_rst_o),
        .cdr_rst_o       (cdr_rst_o),
        .tx_en_o         (tx_en_o),
        .rx_en_o         (rx_en_o),
        .rx_align_rst_o  (rx_align_rst_o),
        .tx_idle_o       (tx_idle_o),
        .link_up         (link_up),
        .seq_state       (seq_state),
        .pll_timeout_err (pll_timeout_err),
        .cdr_timeout_err (cdr_timeout_err),
        .lock_loss_err   (lock_loss_err),
        .retry_cnt       (retry_cnt)
    );

    typedef struct {
        logic       phy_en;
        logic       pll_lock;
        logic       cdr_lock;
        logic       tx_en;
        logic       rx_en;
        logic       tx_idle;
        logic [2:0] st;
        logic [6:0] o;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [6:0] outs();
        return {pll_rst_o, cdr_rst_o, rx_en_o, tx_en_o, rx_align_rst_o, tx_idle_o, link_up};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; phy_en = 1'b0; err_clr = 1'b0;
        pll_rst_cfg = 1'b0; cdr_rst_cfg = 1'b0;
        tx_en_cfg = 1'b1; rx_en_cfg = 1'b1; tx_idle_cfg = 1'b0;
        pll_lock = 1'b1; cdr_lock = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic p, input logic [2:0] cfg, input logic [2:0] st,
                                input logic [6:0] o);
        vec_t v;
        v.phy_en = p; v.pll_lock = 1'b1; v.cdr_lock = 1'b1;
        v.tx_en = cfg[2]; v.rx_en = cfg[1]; v.tx_idle = cfg[0];
        v.st = st; v.o = o;
        return v;
    endfunction

    initial begin
        // Nominal bring-up: entry k is sampled after the (k)th edge with phy_en=1.
        tbl[0] = mk(1'b0, 3'b110, S_OFF, O_OFF);
        for (int i = 1; i <= 4; i++) tbl[i] = mk(1'b1, 3'b110, S_PRST, O_OFF);
        for (int i = 5; i <= 7; i++) tbl[i] = mk(1'b1, 3'b110, S_PWAIT, O_PWAIT);
        for (int i = 8; i <= 9; i++) tbl[i] = mk(1'b1, 3'b110, S_CRST, O_CRST);
        for (int i = 10; i <= 12; i++) tbl[i] = mk(1'b1, 3'b110, S_CWAIT, O_CWAIT);
        tbl[13] = mk(1'b1, 3'b110, S_ALIGN, O_ALIGN);
        tbl[14] = mk(1'b1, 3'b110, S_UP, O_UP);
        tbl[15] = mk(1'b1, 3'b111, S_UP, 7'b0011011);
        tbl[16] = mk(1'b1, 3'b000, S_UP, 7'b0000001);
        tbl[17] = mk(1'b0, 3'b110, S_OFF, O_OFF);

        do_reset();
        chk("reset_state", 16'(seq_state), 16'(S_OFF));
        chk("reset_outs", 16'(outs()), 16'(O_OFF));
        chk("reset_flags", 16'({pll_timeout_err, cdr_timeout_err, lock_loss_err, retry_cnt}),
            16'h0);

        for (int i = 0; i < 18; i++) begin
            phy_en = tbl[i].phy_en; pll_lock = tbl[i].pll_lock; cdr_lock = tbl[i].cdr_lock;
            tx_en_cfg = tbl[i].tx_en; rx_en_cfg = tbl[i].rx_en; tx_idle_cfg = tbl[i].tx_idle;
            step();
            chk($sformatf("tbl%0d_state", i), 16'(seq_state), 16'(tbl[i].st));
            chk($sformatf("tbl%0d_outs", i), 16'(outs()), 16'(tbl[i].o));
        end

        // PLL never locks: two timeouts then ERR.
        do_reset();
        pll_lock = 1'b0; phy_en = 1'b1;
        repeat (24) step();
        chk("nolock_wait_before_to", 16'(seq_state), 16'(S_PWAIT));
        step();
        chk("nolock_retry1_state", 16'(seq_state), 16'(S_PRST));
        chk("nolock_retry1_cnt", 16'(retry_cnt), 16'd1);
        chk("nolock_flag1", 16'(pll_timeout_err), 16'd1);
        repeat (23) step();
        chk("nolock_wait2", 16'(seq_state), 16'(S_PWAIT));
        step();
        chk("nolock_err_state", 16'(seq_state), 16'(S_ERR));
        chk("nolock_err_cnt", 16'(retry_cnt), 16'd2);
        chk("nolock_err_pllrst", 16'(pll_rst_o), 16'd1);
        repeat (3) step();
        chk("nolock_err_holds", 16'(seq_state), 16'(S_ERR));
        phy_en = 1'b0;
        step();
        chk("nolock_off_state", 16'(seq_state), 16'(S_OFF));
        chk("nolock_off_cnt", 16'(retry_cnt), 16'd0);
        chk("nolock_off_flag_kept", 16'(pll_timeout_err), 16'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("errclr_alone_flag", 16'(pll_timeout_err), 16'd0);

        // err_clr coincident with a timeout: the set wins.
        phy_en = 1'b1;
        repeat (24) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("errclr_same_cycle_flag", 16'(pll_timeout_err), 16'd1);
        chk("errclr_same_cycle_state", 16'(seq_state), 16'(S_PRST));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("errclr_retry_zero", 16'(retry_cnt), 16'd0);
        chk("errclr_flag_zero", 16'(pll_timeout_err), 16'd0);

        // Glitchy CDR lock (1,1,0 ...) then a clean lock on the retry.
        do_reset();
        phy_en = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            cdr_lock = ((n % 3) != 0);
            step();
            if (n == 29) chk("glitch_wait_before_to", 16'(seq_state), 16'(S_CWAIT));
        end
        chk("glitch_to_state", 16'(seq_state), 16'(S_CRST));
        chk("glitch_to_flag", 16'(cdr_timeout_err), 16'd1);
        chk("glitch_to_cnt", 16'(retry_cnt), 16'd1);
        cdr_lock = 1'b1;
        repeat (5) step();
        chk("glitch_retry_align", 16'(seq_state), 16'(S_ALIGN));
        step();
        chk("glitch_retry_up", 16'(link_up), 16'd1);

        // PLL lock loss in UP: full relock, retry count untouched.
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        chk("ploss_state", 16'(seq_state), 16'(S_PRST));
        chk("ploss_flag", 16'(lock_loss_err), 16'd1);
        chk("ploss_linkdown", 16'(link_up), 16'd0);
        repeat (12) step();
        chk("ploss_align", 16'(seq_state), 16'(S_ALIGN));
        step();
        chk("ploss_up", 16'(seq_state), 16'(S_UP));
        chk("ploss_retry_kept", 16'(retry_cnt), 16'd1);

        // phy_en dropped mid-PLL_WAIT and mid-CDR_WAIT.
        do_reset();
        pll_lock = 1'b0; phy_en = 1'b1;
        repeat (6) step();
        chk("mid_pwait_state", 16'(seq_state), 16'(S_PWAIT));
        phy_en = 1'b0;
        step();
        chk("mid_pwait_off", 16'(seq_state), 16'(S_OFF));
        chk("mid_pwait_outs", 16'(outs()), 16'(O_OFF));
        pll_lock = 1'b1; cdr_lock = 1'b0; phy_en = 1'b1;
        repeat (11) step();
        chk("mid_cwait_state", 16'(seq_state), 16'(S_CWAIT));
        phy_en = 1'b0;
        step();
        chk("mid_cwait_off", 16'(seq_state), 16'(S_OFF));
        chk("mid_cwait_outs", 16'(outs()), 16'(O_OFF));

        // CDR lock loss in UP, then rst mid-UP.
        cdr_lock = 1'b1; phy_en = 1'b1;
        repeat (14) step();
        chk("pre_closs_up", 16'(seq_state), 16'(S_UP));
        cdr_lock = 1'b0;
        step();
        cdr_lock = 1'b1;
        chk("closs_state", 16'(seq_state), 16'(S_CRST));
        chk("closs_flag", 16'(lock_loss_err), 16'd1);
        repeat (6) step();
        chk("closs_relock_up", 16'(seq_state), 16'(S_UP));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_up_state", 16'(seq_state), 16'(S_OFF));
        chk("rst_up_outs", 16'(outs()), 16'(O_OFF));
        chk("rst_up_flags", 16'({pll_timeout_err, cdr_timeout_err, lock_loss_err, retry_cnt}),
            16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
